// File: rtl/song_seq.sv
// Song sequencer: steps through a fixed note table on a beat timebase and
// presents the current note as octave fields plus a square-wave tone on spk.
module song_seq #(
   parameter int BEAT_CYCLES = 250000,
   parameter int SONG_LEN    = 32,
   parameter int LOOP        = 1
) (
   input  logic       clk_1mhz,
   input  logic       rst,
   input  logic       play,
   input  logic       stop,
   output logic [3:0] high,
   output logic [3:0] med,
   output logic [3:0] low,
   output logic       spk,
   output logic [7:0] note_idx,
   output logic       song_end
);

   localparam int BCW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

   state_t         state_q;
   logic [7:0]     idx_q;
   logic [BCW-1:0] beatCnt_q;
   logic [2:0]     beatsRem_q;
   logic [1:0]     oct_q;
   logic [2:0]     note_q;
   logic [11:0]    toneCnt_q;
   logic           spk_q;
   logic           songEnd_q;
   logic [3:0]     high_q;
   logic [3:0]     med_q;
   logic [3:0]     low_q;

   logic [7:0]     idx_d;
   logic [7:0]     loadIdx;
   logic [7:0]     loadEntry;
   logic [1:0]     loadOct;
   logic [2:0]     loadNote;
   logic [3:0]     loadHigh;
   logic [3:0]     loadMed;
   logic [3:0]     loadLow;
   logic           lastEntry;
   logic           beatTick;
   logic           entryDone;
   logic           sounding;
   logic [11:0]    medHalfPeriod;
   logic [11:0]    halfPeriod;
   logic           toneTop;

   // Entry layout: [7:6] octave, [5:3] note, [2:0] beats-1. Indices past 31 reuse the melody.
   function automatic logic [7:0] songRom(input logic [4:0] i);
      logic [7:0] e;
      e = 8'h00;
      case (i)
         5'd0:  e = 8'h88;
         5'd1:  e = 8'h99;
         5'd2:  e = 8'h00;
         5'd3:  e = 8'hE8;
         5'd4:  e = 8'h88;
         5'd5:  e = 8'h88;
         5'd6:  e = 8'hA8;
         5'd7:  e = 8'hA8;
         5'd8:  e = 8'hB0;
         5'd9:  e = 8'hB0;
         5'd10: e = 8'hA9;
         5'd11: e = 8'hA0;
         5'd12: e = 8'hA0;
         5'd13: e = 8'h98;
         5'd14: e = 8'h98;
         5'd15: e = 8'h90;
         5'd16: e = 8'h90;
         5'd17: e = 8'h89;
         5'd18: e = 8'h00;
         5'd19: e = 8'hC8;
         5'd20: e = 8'hD0;
         5'd21: e = 8'hD8;
         5'd22: e = 8'hD0;
         5'd23: e = 8'hC9;
         5'd24: e = 8'h68;
         5'd25: e = 8'h70;
         5'd26: e = 8'h78;
         5'd27: e = 8'h88;
         5'd28: e = 8'h98;
         5'd29: e = 8'hA8;
         5'd30: e = 8'h00;
         5'd31: e = 8'h8B;
      endcase
      return e;
   endfunction

   function automatic logic [11:0] medHalf(input logic [2:0] n);
      logic [11:0] h;
      case (n)
         3'd1:    h = 12'd1911;
         3'd2:    h = 12'd1703;
         3'd3:    h = 12'd1517;
         3'd4:    h = 12'd1432;
         3'd5:    h = 12'd1276;
         3'd6:    h = 12'd1136;
         3'd7:    h = 12'd1012;
         default: h = 12'd0;
      endcase
      return h;
   endfunction

   always_comb begin
      lastEntry = (idx_q == 8'(SONG_LEN - 1));
      idx_d     = lastEntry ? 8'd0 : idx_q + 8'd1;
      loadIdx   = (state_q == PLAY) ? idx_d : 8'd0;
      loadEntry = songRom(loadIdx[4:0]);
      loadOct   = loadEntry[7:6];
      loadNote  = loadEntry[5:3];
      loadHigh  = ((loadOct == 2'b11) && (loadNote != 3'd0)) ? {1'b0, loadNote} : 4'd0;
      loadMed   = ((loadOct == 2'b10) && (loadNote != 3'd0)) ? {1'b0, loadNote} : 4'd0;
      loadLow   = ((loadOct == 2'b01) && (loadNote != 3'd0)) ? {1'b0, loadNote} : 4'd0;

      beatTick  = (beatCnt_q == BCW'(BEAT_CYCLES - 1));
      entryDone = beatTick && (beatsRem_q == 3'd0);

      sounding      = (oct_q != 2'b00) && (note_q != 3'd0);
      medHalfPeriod = medHalf(note_q);
      case (oct_q)
         2'b01:   halfPeriod = medHalfPeriod << 1;
         2'b11:   halfPeriod = medHalfPeriod >> 1;
         default: halfPeriod = medHalfPeriod;
      endcase
      toneTop = (toneCnt_q == halfPeriod - 12'd1);
   end

   // Beat timing only advances while in PLAY; the cycle that drops into PAUSE
   // still counts, so total PLAY cycles per entry stay exact across pauses.
   always_ff @(posedge clk_1mhz) begin
      if (rst || stop) begin
         state_q    <= IDLE;
         idx_q      <= 8'd0;
         beatCnt_q  <= '0;
         beatsRem_q <= 3'd0;
         oct_q      <= 2'b00;
         note_q     <= 3'd0;
         toneCnt_q  <= 12'd0;
         spk_q      <= 1'b0;
         songEnd_q  <= 1'b0;
         high_q     <= 4'd0;
         med_q      <= 4'd0;
         low_q      <= 4'd0;
      end else begin
         songEnd_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (play) begin
                  state_q    <= PLAY;
                  idx_q      <= loadIdx;
                  beatCnt_q  <= '0;
                  beatsRem_q <= loadEntry[2:0];
                  oct_q      <= loadOct;
                  note_q     <= loadNote;
                  high_q     <= loadHigh;
                  med_q      <= loadMed;
                  low_q      <= loadLow;
                  toneCnt_q  <= 12'd0;
                  spk_q      <= 1'b0;
               end
            end
            PLAY: begin
               if (!play) begin
                  state_q <= PAUSE;
               end
               if (entryDone) begin
                  songEnd_q <= lastEntry;
                  beatCnt_q <= '0;
                  toneCnt_q <= 12'd0;
                  spk_q     <= 1'b0;
                  if (lastEntry && (LOOP == 0)) begin
                     state_q    <= IDLE;
                     idx_q      <= 8'd0;
                     beatsRem_q <= 3'd0;
                     oct_q      <= 2'b00;
                     note_q     <= 3'd0;
                     high_q     <= 4'd0;
                     med_q      <= 4'd0;
                     low_q      <= 4'd0;
                  end else begin
                     idx_q      <= loadIdx;
                     beatsRem_q <= loadEntry[2:0];
                     oct_q      <= loadOct;
                     note_q     <= loadNote;
                     high_q     <= loadHigh;
                     med_q      <= loadMed;
                     low_q      <= loadLow;
                  end
               end else begin
                  beatCnt_q <= beatTick ? '0 : beatCnt_q + BCW'(1);
                  if (beatTick) begin
                     beatsRem_q <= beatsRem_q - 3'd1;
                  end
                  if (!play || !sounding) begin
                     toneCnt_q <= 12'd0;
                     spk_q     <= 1'b0;
                  end else if (toneTop) begin
                     toneCnt_q <= 12'd0;
                     spk_q     <= ~spk_q;
                  end else begin
                     toneCnt_q <= toneCnt_q + 12'd1;
                  end
               end
            end
            PAUSE: begin
               if (play) begin
                  state_q <= PLAY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign high     = high_q;
   assign med      = med_q;
   assign low      = low_q;
   assign spk      = spk_q;
   assign note_idx = idx_q;
   assign song_end = songEnd_q;

endmodule
